// File: rtl/sd_block_cache_pkg.sv
// Shared definitions for the single-line SD block cache: line geometry, FSM states
// and the SD address mapping.
package sd_block_cache_pkg;

    localparam int LINE_BITS     = 4096;
    localparam int WORD_IDX_BITS = 7;
    localparam int TAG_BITS      = 23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIT,
        ST_WB_REQ,
        ST_WB_WAIT,
        ST_FILL_REQ,
        ST_FILL_WAIT,
        ST_FLUSH_DONE
    } state_t;

    // Standard-capacity cards take byte addresses, high-capacity cards take block numbers.
    function automatic logic [31:0] map_block(input logic [TAG_BITS-1:0] tag, input logic sdsc);
        return sdsc ? {tag, 9'b0} : {9'b0, tag};
    endfunction

endpackage

// File: rtl/sd_busy_sync.sv
// Two-flop synchronizer that brings sd_controller's busy flag into the cache clock domain.
module sd_busy_sync (
    input  logic clock,
    input  logic reset,
    input  logic busy,
    output logic busy_s
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta   <= 1'b0;
            busy_s <= 1'b0;
        end else begin
            meta   <= busy;
            busy_s <= meta;
        end
    end

endmodule

// File: rtl/sd_block_cache.sv
// Single-line 512-byte write-back cache in front of sd_controller; serves 32-bit word
// accesses from the held line and moves whole blocks on miss, dirty eviction or flush.
module sd_block_cache
    import sd_block_cache_pkg::*;
#(
    parameter int SDSC = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stb,
    input  logic                 we,
    input  logic [3:0]           sel,
    input  logic [31:0]          addr,
    input  logic [31:0]          wr_data,
    output logic [31:0]          rd_data,
    output logic                 ack,
    input  logic                 flush,
    output logic                 flush_done,
    output logic                 sd_rd_en,
    output logic                 sd_wr_en,
    output logic [31:0]          sd_addr,
    output logic [LINE_BITS-1:0] sd_write_data,
    input  logic [LINE_BITS-1:0] sd_read_data,
    input  logic                 sd_busy
);

    logic [LINE_BITS-1:0]     line;
    logic [TAG_BITS-1:0]      tag;
    logic                     valid;
    logic                     dirty;
    logic                     busy_s;
    state_t                   state;
    state_t                   ret;
    logic [TAG_BITS-1:0]      req_tag;
    logic [WORD_IDX_BITS-1:0] word;
    logic                     hit;

    assign req_tag       = addr[31:9];
    assign word          = addr[8:2];
    assign hit           = valid && (tag == req_tag);
    // The line itself only changes in HIT or at fill completion, so it is stable for a whole write-back.
    assign sd_write_data = line;

    sd_busy_sync u_busy_sync (
        .clock  (clock),
        .reset  (reset),
        .busy   (sd_busy),
        .busy_s (busy_s)
    );

    // Line data carries no reset: contents are meaningless until valid is set by a fill.
    always_ff @(posedge clock) begin
        if (state == ST_FILL_WAIT && !busy_s) begin
            line <= sd_read_data;
        end else if (state == ST_HIT && we) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    line[{word, i[1:0], 3'b000} +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ret        <= ST_IDLE;
            tag        <= '0;
            valid      <= 1'b0;
            dirty      <= 1'b0;
            rd_data    <= '0;
            ack        <= 1'b0;
            flush_done <= 1'b0;
            sd_rd_en   <= 1'b0;
            sd_wr_en   <= 1'b0;
            sd_addr    <= '0;
        end else begin
            ack        <= 1'b0;
            flush_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (flush) begin
                        if (dirty) begin
                            ret   <= ST_FLUSH_DONE;
                            state <= ST_WB_REQ;
                        end else begin
                            state <= ST_FLUSH_DONE;
                        end
                    end else if (stb) begin
                        if (hit) begin
                            state <= ST_HIT;
                        end else if (dirty) begin
                            ret   <= ST_FILL_REQ;
                            state <= ST_WB_REQ;
                        end else begin
                            state <= ST_FILL_REQ;
                        end
                    end
                end
                ST_HIT: begin
                    if (we) begin
                        dirty <= 1'b1;
                    end else begin
                        rd_data <= line[{word, 5'b00000} +: 32];
                    end
                    ack   <= 1'b1;
                    state <= ST_IDLE;
                end
                // The request is held until the synchronized busy confirms sd_controller took it.
                ST_WB_REQ: begin
                    if (busy_s) begin
                        sd_wr_en <= 1'b0;
                        state    <= ST_WB_WAIT;
                    end else begin
                        sd_wr_en <= 1'b1;
                        sd_addr  <= map_block(tag, SDSC != 0);
                    end
                end
                ST_WB_WAIT: begin
                    if (!busy_s) begin
                        dirty <= 1'b0;
                        state <= ret;
                    end
                end
                ST_FILL_REQ: begin
                    if (busy_s) begin
                        sd_rd_en <= 1'b0;
                        state    <= ST_FILL_WAIT;
                    end else begin
                        sd_rd_en <= 1'b1;
                        sd_addr  <= map_block(req_tag, SDSC != 0);
                    end
                end
                ST_FILL_WAIT: begin
                    if (!busy_s) begin
                        tag   <= req_tag;
                        valid <= 1'b1;
                        dirty <= 1'b0;
                        state <= ST_HIT;
                    end
                end
                ST_FLUSH_DONE: begin
                    flush_done <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_block_cache.sv
// Bench for sd_block_cache: word-level memory model plus a line-level traffic model,
// an SD controller responder, and a second SDSC=1 instance for addressing and reset.
module tb_sd_block_cache;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          stb;
    logic          we;
    logic [3:0]    sel;
    logic [31:0]   addr;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data;
    logic          ack;
    logic          flush;
    logic          flush_done;
    logic          sd_rd_en;
    logic          sd_wr_en;
    logic [31:0]   sd_addr;
    logic [4095:0] sd_write_data;
    logic [4095:0] sd_read_data;
    logic          sd_busy;

    logic          reset2;
    logic          stb2;
    logic [31:0]   addr2;
    logic [31:0]   rd_data2;
    logic          ack2;
    logic          flush_done2;
    logic          sd_rd_en2;
    logic          sd_wr_en2;
    logic [31:0]   sd_addr2;
    logic [4095:0] sd_write_data2;
    logic [4095:0] sd_read_data2;
    logic          sd_busy2;

    sd_block_cache #(.SDSC(0)) dut (
        .clock(clock), .reset(reset), .stb(stb), .we(we), .sel(sel), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .ack(ack), .flush(flush),
        .flush_done(flush_done), .sd_rd_en(sd_rd_en), .sd_wr_en(sd_wr_en),
        .sd_addr(sd_addr), .sd_write_data(sd_write_data), .sd_read_data(sd_read_data),
        .sd_busy(sd_busy)
    );

    sd_block_cache #(.SDSC(1)) dut_sdsc (
        .clock(clock), .reset(reset2), .stb(stb2), .we(1'b0), .sel(4'b0000), .addr(addr2),
        .wr_data(32'h0), .rd_data(rd_data2), .ack(ack2), .flush(1'b0),
        .flush_done(flush_done2), .sd_rd_en(sd_rd_en2), .sd_wr_en(sd_wr_en2),
        .sd_addr(sd_addr2), .sd_write_data(sd_write_data2), .sd_read_data(sd_read_data2),
        .sd_busy(sd_busy2)
    );

    typedef struct {
        bit            is_wr;
        logic [31:0]   blk_addr;
        logic [4095:0] data;
    } sd_op_t;

    int checks = 0;
    int errors = 0;

    sd_op_t        obs_q[$];
    sd_op_t        exp_q[$];
    logic [4095:0] sd_store[int];
    logic [31:0]   mem[int];

    bit          m_valid = 0;
    bit          m_dirty = 0;
    int          m_block = 0;
    bit          acc_pending = 0;
    bit          acc_we = 0;
    logic [31:0] exp_rd = '0;
    bit          flush_pending = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic check_block(input string name, input logic [4095:0] actual, input logic [4095:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            for (int i = 0; i < 128; i++) begin
                if (actual[32*i +: 32] !== expected[32*i +: 32]) begin
                    $display("[TB] FAIL %s: word %0d got 0x%08h, expected 0x%08h",
                             name, i, actual[32*i +: 32], expected[32*i +: 32]);
                    break;
                end
            end
        end
    endtask

    // Unwritten storage holds its own global word number.
    function automatic logic [31:0] model_word(input int wa);
        return mem.exists(wa) ? mem[wa] : 32'(wa);
    endfunction

    function automatic logic [4095:0] model_block(input int b);
        logic [4095:0] blk;
        for (int i = 0; i < 128; i++) blk[32*i +: 32] = model_word(b * 128 + i);
        return blk;
    endfunction

    function automatic logic [4095:0] default_block(input int b);
        logic [4095:0] blk;
        for (int i = 0; i < 128; i++) blk[32*i +: 32] = 32'(b * 128 + i);
        return blk;
    endfunction

    // SD controller responder for the SDSC=0 instance: busy rises a little after the request and later falls.
    initial begin
        sd_op_t op;
        int     blk;
        sd_busy      = 1'b0;
        sd_read_data = '0;
        forever begin
            @(negedge clock);
            if (!reset && (sd_rd_en || sd_wr_en)) begin
                blk         = int'(sd_addr);
                op.is_wr    = sd_wr_en;
                op.blk_addr = sd_addr;
                op.data     = sd_write_data;
                if (sd_wr_en) sd_store[blk] = sd_write_data;
                else sd_read_data = sd_store.exists(blk) ? sd_store[blk] : default_block(blk);
                obs_q.push_back(op);
                repeat (2) @(negedge clock);
                sd_busy = 1'b1;
                repeat (6) @(negedge clock);
                sd_busy = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check_output("sd_en_exclusive", {31'b0, sd_rd_en & sd_wr_en}, 32'h0);
            if (ack) begin
                check_output("ack_expected", {31'b0, acc_pending}, 32'h1);
                if (acc_pending && !acc_we) check_output("rd_data", rd_data, exp_rd);
            end
            if (flush_done) check_output("flush_done_expected", {31'b0, flush_pending}, 32'h1);
        end
    end

    task automatic apply_stimulus(input bit w, input logic [3:0] s, input logic [31:0] a,
                                  input logic [31:0] d, output int cycles, output logic [31:0] rdata);
        int     b;
        int     wa;
        bit     exp_hit;
        sd_op_t op;
        b       = int'(a >> 9);
        wa      = int'(a >> 2);
        exp_hit = m_valid && (m_block == b);
        if (!exp_hit) begin
            if (m_dirty) begin
                op.is_wr = 1; op.blk_addr = 32'(m_block); op.data = model_block(m_block);
                exp_q.push_back(op);
            end
            op.is_wr = 0; op.blk_addr = 32'(b); op.data = '0;
            exp_q.push_back(op);
            m_valid = 1; m_block = b; m_dirty = 0;
        end
        if (w) begin
            logic [31:0] cur;
            cur = model_word(wa);
            for (int i = 0; i < 4; i++) if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
            mem[wa] = cur;
            m_dirty = 1;
        end
        exp_rd      = model_word(wa);
        acc_we      = w;
        acc_pending = 1;
        @(posedge clock); #1;
        stb = 1'b1; we = w; sel = s; addr = a; wr_data = d;
        cycles = 0;
        rdata  = '0;
        while (cycles < 2000) begin
            @(posedge clock);
            cycles++;
            @(negedge clock);
            if (ack) break;
        end
        rdata = rd_data;
        if (!ack) check_output("ack_timeout", cycles, 32'hFFFF_FFFF);
        if (exp_hit) check_output("hit_latency", cycles, 2);
        stb = 1'b0;
        @(posedge clock); #1;
        acc_pending = 0;
    endtask

    task automatic do_flush(output int cycles);
        sd_op_t op;
        if (m_dirty) begin
            op.is_wr = 1; op.blk_addr = 32'(m_block); op.data = model_block(m_block);
            exp_q.push_back(op);
            m_dirty = 0;
        end
        flush_pending = 1;
        @(posedge clock); #1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush  = 1'b0;
        cycles = 1;
        @(negedge clock);
        while (!flush_done && cycles < 2000) begin
            @(posedge clock);
            cycles++;
            @(negedge clock);
        end
        if (!flush_done) check_output("flush_timeout", cycles, 32'hFFFF_FFFF);
        @(posedge clock); #1;
        flush_pending = 0;
    endtask

    task automatic check_sd_traffic(input string name);
        int n;
        check_output({name, "_op_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_output({name, "_op_kind"}, {31'b0, obs_q[i].is_wr}, {31'b0, exp_q[i].is_wr});
            check_output({name, "_op_addr"}, obs_q[i].blk_addr, exp_q[i].blk_addr);
            if (exp_q[i].is_wr) check_block({name, "_wb_data"}, obs_q[i].data, exp_q[i].data);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          cyc;
        int          n;
        logic [31:0] rv;
        stb = 0; we = 0; sel = 0; addr = 0; wr_data = 0; flush = 0;
        stb2 = 0; addr2 = 0; sd_busy2 = 0; sd_read_data2 = '0;
        reset = 1'b1; reset2 = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_output("reset_rd_data", rd_data, 0);
        check_output("reset_ctrl", {26'b0, ack, flush_done, sd_rd_en, sd_wr_en, 2'b00}, 0);
        check_output("reset_sd_addr", sd_addr, 0);
        reset = 1'b0; reset2 = 1'b0;

        apply_stimulus(0, 4'h0, 32'h0000_0204, 32'h0, cyc, rv);
        check_output("cold_read_literal", rv, 32'h81);
        check_output("cold_read_one_op", obs_q.size(), 1);
        check_output("cold_read_addr_literal", obs_q[0].blk_addr, 32'h1);
        check_sd_traffic("cold_read");

        apply_stimulus(0, 4'h0, 32'h0000_0208, 32'h0, cyc, rv);
        check_output("hit_read_literal", rv, 32'h82);
        check_output("hit_latency_literal", cyc, 2);
        check_sd_traffic("hit_read");

        apply_stimulus(1, 4'b0101, 32'h0000_0204, 32'hDEAD_BEEF, cyc, rv);
        apply_stimulus(0, 4'h0, 32'h0000_0204, 32'h0, cyc, rv);
        check_output("merge_literal", rv, 32'h00AD_00EF);
        check_sd_traffic("hit_write");

        apply_stimulus(0, 4'h0, 32'h0000_0400, 32'h0, cyc, rv);
        check_output("evict_first_is_write", {31'b0, obs_q[0].is_wr}, 1);
        check_output("evict_wb_addr_literal", obs_q[0].blk_addr, 32'h1);
        check_output("evict_wb_word_literal", obs_q[0].data[63:32], 32'h00AD_00EF);
        check_output("evict_fill_addr_literal", obs_q[1].blk_addr, 32'h2);
        check_sd_traffic("evict");

        apply_stimulus(1, 4'b1111, 32'h0000_0404, 32'h1234_5678, cyc, rv);
        apply_stimulus(1, 4'b0000, 32'h0000_0800, 32'hFFFF_FFFF, cyc, rv);
        check_sd_traffic("zero_sel_write_miss");

        do_flush(cyc);
        check_output("flush_dirty_one_op", obs_q.size(), 1);
        check_sd_traffic("flush_dirty");
        do_flush(cyc);
        check_output("flush_clean_latency", cyc, 2);
        check_sd_traffic("flush_clean");

        apply_stimulus(0, 4'h0, 32'h0000_0408, 32'h0, cyc, rv);
        apply_stimulus(0, 4'h0, 32'h0000_0404, 32'h0, cyc, rv);
        check_output("writeback_persisted", rv, 32'h1234_5678);
        apply_stimulus(1, 4'b0011, 32'h0000_0A10, 32'hCAFE_F00D, cyc, rv);
        apply_stimulus(0, 4'h0, 32'h0000_0A10, 32'h0, cyc, rv);
        check_sd_traffic("write_allocate");

        // SDSC=1 instance: byte addressing, then reset while the fill is outstanding.
        @(posedge clock); #1;
        stb2 = 1'b1; addr2 = 32'h0000_0600;
        n = 0;
        while (!sd_rd_en2 && n < 50) begin @(negedge clock); n++; end
        check_output("sdsc_rd_en_seen", {31'b0, sd_rd_en2}, 1);
        check_output("sdsc_addr", sd_addr2, 32'h0000_0600);
        sd_busy2 = 1'b1;
        n = 0;
        while (sd_rd_en2 && n < 50) begin @(negedge clock); n++; end
        check_output("sdsc_rd_en_dropped", {31'b0, sd_rd_en2}, 0);
        repeat (2) @(negedge clock);
        reset2 = 1'b1;
        #1;
        check_output("midreset_rd_data", rd_data2, 0);
        check_output("midreset_ctrl", {28'b0, ack2, flush_done2, sd_rd_en2, sd_wr_en2}, 0);
        check_output("midreset_sd_addr", sd_addr2, 0);
        sd_busy2 = 1'b0;
        stb2     = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset2 = 1'b0;
        stb2   = 1'b1;
        n = 0;
        while (!sd_rd_en2 && n < 50) begin @(negedge clock); n++; end
        check_output("refetch_after_reset", {31'b0, sd_rd_en2}, 1);
        reset2 = 1'b1;
        stb2   = 1'b0;
        repeat (2) @(posedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
